// File: rtl/axis_video_pattern_source.sv
// AXI4-Stream synthetic video source: ramp, colour bars, solid and coordinate patterns,
// one pixel per cycle with SOF on tuser and EOL on tlast, optional idle gap between frames.
module axis_video_pattern_source #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FRAME_GAP  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [23:0]           solid_rgb,
  input  logic [15:0]           num_frames,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam int unsigned GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state, state_n;
  logic [XW-1:0]         x_q, x_n;
  logic [YW-1:0]         y_q, y_n;
  logic [15:0]           frames_q, frames_n;
  logic [GW-1:0]         gap_q, gap_n;
  logic [1:0]            sel_q, sel_n;
  logic [23:0]           rgb_q, rgb_n;
  logic [15:0]           nf_q, nf_n;
  logic [DATA_WIDTH-1:0] tdata_n;
  logic                  tvalid_n, tuser_n, tlast_n, busy_n, done_n;
  logic                  load;

  // Pixel value for coordinate (px,py) under the given pattern, packed as g[9:2], b[19:12], r[29:22].
  function automatic logic [DATA_WIDTH-1:0] pixel(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                                  input logic [1:0] sel, input logic [23:0] rgb);
    logic [7:0]            k, r, g, b;
    logic [2:0]            bar;
    logic [11:0]           x12, y12;
    logic [DATA_WIDTH-1:0] d;
    x12 = 12'(px);
    y12 = 12'(py);
    k   = 8'(32'(py) * 32'(H_ACTIVE) + 32'(px));
    bar = 3'((32'(px) * 32'd8) / 32'(H_ACTIVE));
    case (sel)
      2'd0:    begin r = 8'hFF - k; g = k; b = 8'd0 - {k[6:0], 1'b0}; end
      2'd1:    begin r = {8{bar[2]}}; g = {8{bar[1]}}; b = {8{bar[0]}}; end
      2'd2:    begin r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0]; end
      default: begin r = x12[7:0]; g = y12[7:0]; b = {x12[11:8], y12[11:8]}; end
    endcase
    d        = '0;
    d[29:22] = r;
    d[19:12] = b;
    d[9:2]   = g;
    return d;
  endfunction

  // Next-state and next-output logic; outputs only move on a transfer or a state change.
  always_comb begin
    state_n  = state;
    x_n      = x_q;
    y_n      = y_q;
    frames_n = frames_q;
    gap_n    = gap_q;
    sel_n    = sel_q;
    rgb_n    = rgb_q;
    nf_n     = nf_q;
    tvalid_n = m_axis_video_tvalid;
    tuser_n  = m_axis_video_tuser;
    tlast_n  = m_axis_video_tlast;
    tdata_n  = m_axis_video_tdata;
    done_n   = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE: if (enable) begin
        sel_n    = pattern_sel;
        rgb_n    = solid_rgb;
        nf_n     = num_frames;
        frames_n = '0;
        state_n  = S_SEND;
        load     = 1'b1;
      end
      S_SEND: if (m_axis_video_tvalid && m_axis_video_tready) begin
        if (x_q != X_LAST) begin
          x_n  = x_q + XW'(1);
          load = 1'b1;
        end else begin
          x_n = '0;
          if (y_q != Y_LAST) begin
            y_n  = y_q + YW'(1);
            load = 1'b1;
          end else begin
            y_n      = '0;
            done_n   = 1'b1;
            frames_n = frames_q + 16'd1;
            tvalid_n = 1'b0;
            tuser_n  = 1'b0;
            tlast_n  = 1'b0;
            tdata_n  = '0;
            if ((nf_q != 16'd0) && (frames_n == nf_q)) begin
              state_n = S_DONE;
            end else if (!enable) begin
              state_n = S_IDLE;
            end else if (FRAME_GAP == 0) begin
              load = 1'b1;
            end else begin
              state_n = S_GAP;
              gap_n   = '0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          if (enable) begin
            state_n = S_SEND;
            load    = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      S_DONE: if (!enable) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      tvalid_n = 1'b1;
      tdata_n  = pixel(x_n, y_n, sel_n, rgb_n);
      tuser_n  = (x_n == '0) && (y_n == '0);
      tlast_n  = (x_n == X_LAST);
    end
    busy_n = (state_n == S_SEND) || (state_n == S_GAP);
  end

  // State and registered outputs; reset wins over the clock enable.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state               <= S_IDLE;
      x_q                 <= '0;
      y_q                 <= '0;
      frames_q            <= '0;
      gap_q               <= '0;
      sel_q               <= '0;
      rgb_q               <= '0;
      nf_q                <= '0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
    end else if (aclken) begin
      state               <= state_n;
      x_q                 <= x_n;
      y_q                 <= y_n;
      frames_q            <= frames_n;
      gap_q               <= gap_n;
      sel_q               <= sel_n;
      rgb_q               <= rgb_n;
      nf_q                <= nf_n;
      m_axis_video_tdata  <= tdata_n;
      m_axis_video_tvalid <= tvalid_n;
      m_axis_video_tuser  <= tuser_n;
      m_axis_video_tlast  <= tlast_n;
      busy                <= busy_n;
      frame_done          <= done_n;
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_source.sv
// Self-checking bench for axis_video_pattern_source: per-cycle compare against a pixel-index model,
// randomized tready/aclken, plus literal pixel values for each pattern.
`timescale 1ns/1ps
module tb_axis_video_pattern_source;
  localparam int unsigned H   = 8;
  localparam int unsigned V   = 4;
  localparam int unsigned GAP = 2;
  localparam int unsigned DW  = 64;
  localparam int          N   = H * V;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [23:0]   solid_rgb = 24'd0;
  logic [15:0]   num_frames = 16'd0;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, busy, frame_done;
  logic          tready = 1'b1;

  axis_video_pattern_source #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .FRAME_GAP(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .num_frames(num_frames),
    .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast), .busy(busy), .frame_done(frame_done));

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected pixel for linear index idx within a frame, straight from the pattern definitions.
  function automatic logic [63:0] model_pix(input int idx, input int sel, input logic [23:0] rgb);
    int x, y, k, bar, r, g, b;
    x = idx % H;
    y = idx / H;
    k = idx % 256;
    case (sel)
      0: begin r = 255 - k; g = k; b = (1024 - 2 * k) % 256; end
      1: begin
        bar = x * 8 / H;
        r = ((bar & 4) != 0) ? 255 : 0;
        g = ((bar & 2) != 0) ? 255 : 0;
        b = ((bar & 1) != 0) ? 255 : 0;
      end
      2: begin r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]); end
      default: begin r = x % 256; g = y % 256; b = ((x / 256) % 16) * 16 + (y / 256) % 16; end
    endcase
    return 64'(r) * 64'h40_0000 + 64'(b) * 64'h1000 + 64'(g) * 64'd4;
  endfunction

  // Scoreboard state
  int           beat_idx = 0, beats_acc = 0, frames_acc = 0;
  int           tuser_cnt = 0, tlast_cnt = 0, fd_cnt = 0;
  int           cur_sel = 0;
  logic [23:0]  cur_rgb = 24'd0;
  logic         exp_fd = 1'b0, pend = 1'b0, mon_en = 1'b0;
  logic         rdy_rand = 1'b0, ce_rand = 1'b0;
  logic [63:0]  cap [N];

  // Compare process: outputs sampled mid-cycle, inputs seen here are what the next edge samples.
  always @(negedge aclk) begin
    logic acc;
    if (mon_en) begin
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (frame_done) fd_cnt++;
      if (pend) chk("tvalid_held", 64'(tvalid), 64'(1));
      if (tvalid) begin
        chk("tdata", tdata, model_pix(beat_idx, cur_sel, cur_rgb));
        chk("tuser", 64'(tuser), 64'(beat_idx == 0));
        chk("tlast", 64'(tlast), 64'((beat_idx % H) == (H - 1)));
        chk("busy_while_valid", 64'(busy), 64'(1));
      end
      acc = tvalid && tready && aclken && aresetn;
      if (!aresetn) begin
        exp_fd   = 1'b0;
        pend     = 1'b0;
        beat_idx = 0;
      end else if (aclken) begin
        exp_fd = acc && (beat_idx == N - 1);
        pend   = tvalid && !tready;
        if (acc) begin
          cap[beat_idx] = tdata;
          beats_acc++;
          if (tuser) tuser_cnt++;
          if (tlast) tlast_cnt++;
          if (beat_idx == N - 1) begin
            beat_idx = 0;
            frames_acc++;
          end else begin
            beat_idx++;
          end
        end
      end else begin
        pend = tvalid;
      end
    end
  end

  // Sink/enable stimulus: random tready and aclken when requested.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      aclken = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_run(input int sel, input logic [23:0] rgb, input logic [15:0] nf);
    cur_sel     = sel;
    cur_rgb     = rgb;
    pattern_sel = 2'(sel);
    solid_rgb   = rgb;
    num_frames  = nf;
    enable      = 1'b1;
  endtask

  task automatic stop_run();
    tick();
    enable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_acc < target && n < budget) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("wait_frames_timeout", 64'(frames_acc >= target), 64'(1));
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats_acc < target && n < budget) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("wait_beats_timeout", 64'(beats_acc >= target), 64'(1));
  endtask

  int   b0, f0, u0, l0, d0;
  logic q[$];

  initial begin
    int ones, first, last, run, runs, vcnt;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tdata", tdata, 64'(0));
    chk("rst_tuser", 64'(tuser), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    tick();
    aresetn = 1'b1;
    mon_en  = 1'b1;
    repeat (2) tick();

    // Single ramp frame, tready always high
    b0 = beats_acc; f0 = frames_acc; u0 = tuser_cnt; l0 = tlast_cnt; d0 = fd_cnt;
    start_run(0, 24'd0, 16'd1);
    tick();
    @(negedge aclk);
    chk("s1_first_tvalid", 64'(tvalid), 64'(1));
    chk("s1_first_tdata", tdata, 64'h3FC0_0000);
    chk("s1_first_tuser", 64'(tuser), 64'(1));
    wait_frames(f0 + 1, 200);
    repeat (3) @(negedge aclk);
    chk("s1_beats", 64'(beats_acc - b0), 64'(32));
    chk("s1_tuser_count", 64'(tuser_cnt - u0), 64'(1));
    chk("s1_tlast_count", 64'(tlast_cnt - l0), 64'(4));
    chk("s1_frame_done_count", 64'(fd_cnt - d0), 64'(1));
    chk("s1_beat1_tdata", cap[1], 64'h3F8F_E004);
    chk("s1_done_tvalid", 64'(tvalid), 64'(0));
    chk("s1_done_busy", 64'(busy), 64'(0));
    stop_run();

    // Same frame with a stalling sink; configuration changes mid-frame must not take effect
    b0 = beats_acc; f0 = frames_acc;
    rdy_rand = 1'b1;
    start_run(0, 24'd0, 16'd1);
    repeat (3) tick();
    pattern_sel = 2'd2;
    solid_rgb   = 24'hFFFFFF;
    wait_frames(f0 + 1, 400);
    rdy_rand = 1'b0;
    chk("s2_beats", 64'(beats_acc - b0), 64'(32));
    chk("s2_last_tdata", cap[31], 64'h380C_207C);
    stop_run();

    // Three frames with the inter-frame gap
    b0 = beats_acc; f0 = frames_acc; d0 = fd_cnt;
    start_run(0, 24'd0, 16'd3);
    q.delete();
    for (int i = 0; i < 130; i++) begin
      @(negedge aclk);
      q.push_back(tvalid);
    end
    ones = 0; first = -1; last = -1;
    foreach (q[i]) if (q[i]) begin
      ones++;
      if (first < 0) first = i;
      last = i;
    end
    run = 0; runs = 0;
    for (int i = first; i <= last && first >= 0; i++) begin
      if (!q[i]) run++;
      else if (run != 0) begin
        runs++;
        chk("s3_gap_len", 64'(run), 64'(GAP));
        run = 0;
      end
    end
    chk("s3_valid_cycles", 64'(ones), 64'(96));
    chk("s3_gap_count", 64'(runs), 64'(2));
    chk("s3_frames", 64'(frames_acc - f0), 64'(3));
    chk("s3_frame_done_count", 64'(fd_cnt - d0), 64'(3));
    chk("s3_busy_after", 64'(busy), 64'(0));
    stop_run();

    // enable dropped mid-frame: frame completes, nothing follows
    b0 = beats_acc; f0 = frames_acc; u0 = tuser_cnt;
    start_run(3, 24'd0, 16'd0);
    wait_beats(b0 + 10, 100);
    tick();
    enable = 1'b0;
    wait_frames(f0 + 1, 200);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (tvalid) vcnt++;
    end
    chk("s4_beats", 64'(beats_acc - b0), 64'(32));
    chk("s4_no_valid_after", 64'(vcnt), 64'(0));
    chk("s4_tuser_count", 64'(tuser_cnt - u0), 64'(1));
    chk("s4_frames", 64'(frames_acc - f0), 64'(1));
    chk("s4_busy_after", 64'(busy), 64'(0));
    chk("s4_coord_x1y1", cap[9], 64'h0040_0004);
    repeat (2) tick();

    // Reset mid-frame, then restart from pixel (0,0)
    b0 = beats_acc; f0 = frames_acc;
    start_run(0, 24'd0, 16'd0);
    wait_beats(b0 + 12, 100);
    tick();
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    chk("s5_rst_tvalid", 64'(tvalid), 64'(0));
    chk("s5_rst_busy", 64'(busy), 64'(0));
    chk("s5_no_frame", 64'(frames_acc - f0), 64'(0));
    tick();
    aresetn = 1'b1;
    tick();
    @(negedge aclk);
    chk("s5_restart_tvalid", 64'(tvalid), 64'(1));
    chk("s5_restart_tuser", 64'(tuser), 64'(1));
    chk("s5_restart_tdata", tdata, 64'h3FC0_0000);
    wait_frames(f0 + 1, 200);
    stop_run();
    repeat (4) tick();

    // Colour bars
    f0 = frames_acc;
    start_run(1, 24'd0, 16'd1);
    wait_frames(f0 + 1, 200);
    chk("s6_bars_x0", cap[0], 64'h0);
    chk("s6_bars_x3", cap[3], 64'h000F_F3FC);
    chk("s6_bars_x7", cap[7], 64'h3FCF_F3FC);
    stop_run();

    // Solid colour, input changed after start
    f0 = frames_acc;
    start_run(2, 24'h123456, 16'd1);
    repeat (3) tick();
    solid_rgb = 24'hABCDEF;
    wait_frames(f0 + 1, 200);
    chk("s6_solid_first", cap[0], 64'h0485_60D0);
    chk("s6_solid_last", cap[31], 64'h0485_60D0);
    stop_run();

    // Coordinate pattern under random tready and random clock enable
    b0 = beats_acc; f0 = frames_acc;
    rdy_rand = 1'b1;
    ce_rand  = 1'b1;
    start_run(3, 24'd0, 16'd2);
    wait_frames(f0 + 2, 2000);
    rdy_rand = 1'b0;
    ce_rand  = 1'b0;
    repeat (6) tick();
    @(negedge aclk);
    chk("s7_beats", 64'(beats_acc - b0), 64'(64));
    chk("s7_frames", 64'(frames_acc - f0), 64'(2));
    chk("s7_done_busy", 64'(busy), 64'(0));
    chk("s7_done_tvalid", 64'(tvalid), 64'(0));
    stop_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
